fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register, drives the instruction-memory word address, and captures the fetched word into the IF/ID pipeline register feeding decode.
- Obeys the hazard unit's load-use stall and the branch unit's redirect.
- Keeps fetch and stall statistics counters for the bench.

Parameters:
- IMEM_AW, 5, instruction-memory word-address width (32 words).
- PC_RESET, 32'h0000_0000, PC value loaded during reset.
- CNT_W, 16, width of statistics counters.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  32  redirect target; bits [1:0] ignored.
- imem_instr  in  32  combinational read data from instruction memory.
- imem_addr  out  IMEM_AW  word address = PC[IMEM_AW+1:2].
- PC  out  32  current fetch PC.
- IFID_instr  out  32  instruction register to decode.
- IFID_PC4  out  32  PC+4 of the instruction in IFID_instr.
- IFID_valid  out  1  IF/ID holds a real instruction (not a bubble).
- fetch_count  out  CNT_W  instructions accepted into IF/ID.
- stall_count  out  CNT_W  cycles the stall input held fetch.

Behaviour:
- Reset (reset==0, asynchronous): PC=PC_RESET, IFID_instr=0, IFID_PC4=0, IFID_valid=0, fetch_count=0, stall_count=0. All outputs take these values immediately, without waiting for a clock edge.
- Reset release: first rising edge with reset==1 performs a normal fetch of PC_RESET.
- imem_addr is combinational from PC. imem_instr is read the same cycle, so fetch latency is 0 cycles to IF/ID input and 1 cycle to IFID_instr.
- Priority per rising edge: redirect > stall > normal.
- Normal (no stall, no redirect):
  - PC <= PC+4.
  - IFID_instr <= imem_instr; IFID_PC4 <= PC+4; IFID_valid <= 1.
  - fetch_count++.
- Stall (stall=1, branch_taken=0):
  - PC, IFID_instr, IFID_PC4 and IFID_valid are held.
  - stall_count++.
  - The bench sees the same PC on two consecutive negedges.
- Redirect (branch_taken=1, regardless of stall): PC <= {branch_target[31:2],2'b00}. IF/ID update is governed by the Optional Feature.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- imem_addr takes the low bits only. PC beyond memory aliases; no error.
- Counters saturate at all-ones and do not wrap.
- A stall and a redirect in the same cycle increment neither counter.
- A bubble word is 32'h0 (decode treats 0 as NOP / sll $0,$0,0).
- No internal state machine beyond the registers above. The stage is purely registered: NORMAL / HOLD / REDIRECT is selected each cycle by the inputs.

Optional Feature:
- Macro BRANCH_FLUSH_EN.
- Defined: on redirect, IF/ID is squashed: IFID_instr <= 0, IFID_valid <= 0, IFID_PC4 held. fetch_count is not incremented.
- Undefined: MIPS delay-slot semantics. On redirect, IF/ID captures imem_instr at the current PC exactly as a normal fetch (IFID_valid <= 1, fetch_count++). Only the PC is redirected.

Decomposition:
- Shared package / header fetch_defs: NOP_INSTR = 32'h0, PC_STEP = 4, reset PC constant.
- One natural sub-module, ifid_reg: IF/ID register with load-enable and flush inputs and async active-low reset. fetch_stage instantiates it; PC logic and counters stay in the parent.

Test Plan:
- Hold reset low 4 cycles with imem loaded, then release → PC=0,4,8,12 on successive edges; IFID_instr follows mem[0],mem[1],…; IFID_valid=1 after first edge; fetch_count=3 after 3 edges.
- At PC=40, assert stall for 1 cycle → PC stays 40 for two consecutive negedges; IFID_instr unchanged; stall_count=1; PC=44 on the next edge.
- At PC=20, assert branch_taken with branch_target=32'h0000_0043 →
  - PC=32'h40 next cycle.
  - With BRANCH_FLUSH_EN: IFID_instr=0, IFID_valid=0.
  - Without it: IFID_instr=mem[5], IFID_valid=1.
- Assert stall and branch_taken together at PC=60, target=8 → PC=8 next edge; stall_count and fetch_count unchanged.
- Force PC to 32'hFFFF_FFFC via redirect, then run one free cycle → PC=0, imem_addr=0.
- Pull reset low mid-run (PC=72, counters non-zero) between clock edges → all outputs return to reset values immediately. After release, fetch restarts at PC_RESET.

Source files
------------

// File: rtl/fetch_defs_pkg.sv
// Shared constants for the instruction-fetch stage.
//   NOP_INSTR        : bubble word injected into IF/ID (sll $0,$0,0)
//   PC_STEP          : sequential PC increment
//   PC_RESET_DEFAULT : default PC loaded during reset
//   word_align()     : clears the byte-offset bits of an address
package fetch_defs;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    // Force an address onto a word boundary; uses every input bit.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture i_instr / i_pc4 and mark the entry valid
//   i_flush    : squash to a bubble (instr = NOP, valid = 0, pc4 held);
//                wins over i_load
//   i_instr    : fetched instruction word
//   i_pc4      : PC+4 of the fetched instruction
//   o_instr    : registered instruction to decode
//   o_pc4      : registered PC+4
//   o_valid    : entry holds a real instruction
module ifid_reg
    import fetch_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Flush beats load; with neither asserted the entry is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives the instruction-memory word address and fills the
// IF/ID register. Each edge picks redirect > stall > normal fetch.
// Build option: define BRANCH_FLUSH_EN to squash IF/ID on a redirect;
// otherwise the redirecting cycle still fetches (delay-slot semantics).
//   clock, reset   : clock, asynchronous active-low reset
//   stall          : hazard unit hold of PC and IF/ID
//   branch_taken   : redirect request
//   branch_target  : redirect target (bits [1:0] ignored)
//   imem_instr     : combinational instruction-memory read data
//   imem_addr      : word address PC[IMEM_AW+1:2]
//   PC             : current fetch PC
//   IFID_instr     : instruction to decode
//   IFID_PC4       : PC+4 of IFID_instr
//   IFID_valid     : IF/ID holds a real instruction
//   fetch_count    : saturating count of instructions accepted into IF/ID
//   stall_count    : saturating count of cycles held by stall
module fetch_stage
    import fetch_defs::*;
#(
    parameter int unsigned IMEM_AW  = 5,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic [31:0]        imem_instr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        PC,
    output logic [31:0]        IFID_instr,
    output logic [31:0]        IFID_PC4,
    output logic               IFID_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count
);

`ifdef BRANCH_FLUSH_EN
    localparam logic FLUSH_ON_REDIRECT = 1'b1;
`else
    localparam logic FLUSH_ON_REDIRECT = 1'b0;
`endif

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_normal;
    logic        w_hold;
    logic        w_ifid_load;
    logic        w_ifid_flush;
    logic        w_fetch_inc;

    assign w_pc_plus4 = r_pc + PC_STEP;            // 32-bit modulo wrap
    assign w_target   = word_align(branch_target);
    assign w_normal   = !stall && !branch_taken;
    assign w_hold     = stall && !branch_taken;

    // Redirect either squashes IF/ID or fetches like a normal cycle.
    assign w_ifid_flush = branch_taken && FLUSH_ON_REDIRECT;
    assign w_ifid_load  = w_normal || (branch_taken && !FLUSH_ON_REDIRECT);

    // A stall coinciding with a redirect is not counted as a fetch.
    assign w_fetch_inc  = w_normal || (branch_taken && !stall && !FLUSH_ON_REDIRECT);

    // PC register: redirect > stall hold > sequential.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
        end else if (branch_taken) begin
            r_pc <= w_target;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fetch_inc && (r_fetch_cnt != {CNT_W{1'b1}})) begin
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
            if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clock),
        .rst_n   (reset),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_instr (imem_instr),
        .i_pc4   (w_pc_plus4),
        .o_instr (IFID_instr),
        .o_pc4   (IFID_PC4),
        .o_valid (IFID_valid)
    );

    assign imem_addr   = r_pc[IMEM_AW+1:2];
    assign PC          = r_pc;
    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirect,
// stall+redirect, PC wrap and asynchronous mid-run reset.
module tb_fetch_stage;

`ifdef BRANCH_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [4:0]  imem_addr;
    logic [31:0] PC;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_PC4;
    logic        IFID_valid;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;

    logic [31:0] mem [32];
    int checks;
    int errors;

    assign imem_instr = mem[imem_addr];

    fetch_stage #(
        .IMEM_AW  (5),
        .PC_RESET (32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_instr    (imem_instr),
        .imem_addr     (imem_addr),
        .PC            (PC),
        .IFID_instr    (IFID_instr),
        .IFID_PC4      (IFID_PC4),
        .IFID_valid    (IFID_valid),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let one rising edge pass, land on the negedge.
    task automatic cycle(input logic s, input logic b, input logic [31:0] tgt);
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] instr_before;
        logic [31:0] exp_fetch;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = {16'hC0DE, 16'(i)};
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        reset         = 1'b0;

        // Reset held for 4 cycles
        repeat (4) @(negedge clock);
        chk("rst_pc",     PC, 32'h0);
        chk("rst_addr",   32'(imem_addr), 32'h0);
        chk("rst_instr",  IFID_instr, 32'h0);
        chk("rst_pc4",    IFID_PC4, 32'h0);
        chk("rst_valid",  32'(IFID_valid), 32'h0);
        chk("rst_fcnt",   32'(fetch_count), 32'h0);
        chk("rst_scnt",   32'(stall_count), 32'h0);

        // Release: sequential fetch
        reset = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        chk("e1_pc",    PC, 32'd4);
        chk("e1_instr", IFID_instr, mem[0]);
        chk("e1_pc4",   IFID_PC4, 32'd4);
        chk("e1_valid", 32'(IFID_valid), 32'h1);
        cycle(1'b0, 1'b0, 32'h0);
        chk("e2_pc",    PC, 32'd8);
        chk("e2_instr", IFID_instr, mem[1]);
        cycle(1'b0, 1'b0, 32'h0);
        chk("e3_pc",    PC, 32'd12);
        chk("e3_instr", IFID_instr, mem[2]);
        chk("e3_fcnt",  32'(fetch_count), 32'd3);

        for (int e = 4; e <= 10; e++) begin
            cycle(1'b0, 1'b0, 32'h0);
            chk("seq_pc", PC, 32'(e * 4));
        end
        chk("e10_instr", IFID_instr, mem[9]);
        chk("e10_pc4",   IFID_PC4, 32'd40);
        chk("e10_fcnt",  32'(fetch_count), 32'd10);

        // One-cycle stall at PC=40
        pc_before    = PC;
        instr_before = IFID_instr;
        cycle(1'b1, 1'b0, 32'h0);
        chk("stall_pc",    PC, pc_before);
        chk("stall_pc40",  PC, 32'd40);
        chk("stall_instr", IFID_instr, instr_before);
        chk("stall_valid", 32'(IFID_valid), 32'h1);
        chk("stall_scnt",  32'(stall_count), 32'd1);
        chk("stall_fcnt",  32'(fetch_count), 32'd10);
        cycle(1'b0, 1'b0, 32'h0);
        chk("post_stall_pc",    PC, 32'd44);
        chk("post_stall_instr", IFID_instr, mem[10]);
        chk("post_stall_fcnt",  32'(fetch_count), 32'd11);

        // Redirect from 44 to 20
        cycle(1'b0, 1'b1, 32'd20);
        exp_fetch = FLUSH ? 32'd11 : 32'd12;
        chk("br20_pc",    PC, 32'd20);
        chk("br20_instr", IFID_instr, FLUSH ? 32'h0 : mem[11]);
        chk("br20_pc4",   IFID_PC4, FLUSH ? 32'd44 : 32'd48);
        chk("br20_fcnt",  32'(fetch_count), exp_fetch);

        // Redirect at PC=20 to unaligned 0x43
        cycle(1'b0, 1'b1, 32'h0000_0043);
        exp_fetch = FLUSH ? 32'd11 : 32'd13;
        chk("br43_pc",    PC, 32'h40);
        chk("br43_addr",  32'(imem_addr), 32'd16);
        chk("br43_instr", IFID_instr, FLUSH ? 32'h0 : mem[5]);
        chk("br43_valid", 32'(IFID_valid), FLUSH ? 32'h0 : 32'h1);
        chk("br43_pc4",   IFID_PC4, FLUSH ? 32'd44 : 32'd24);
        chk("br43_fcnt",  32'(fetch_count), exp_fetch);

        // Move to PC=60, then stall and redirect together
        cycle(1'b0, 1'b1, 32'd60);
        exp_fetch = FLUSH ? 32'd11 : 32'd14;
        chk("br60_pc",   PC, 32'd60);
        chk("br60_fcnt", 32'(fetch_count), exp_fetch);
        cycle(1'b1, 1'b1, 32'd8);
        chk("sb_pc",   PC, 32'd8);
        chk("sb_fcnt", 32'(fetch_count), exp_fetch);
        chk("sb_scnt", 32'(stall_count), 32'd1);

        // PC wrap through 0xFFFF_FFFC
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc_top", PC, 32'hFFFF_FFFC);
        chk("wrap_addr31", 32'(imem_addr), 32'd31);
        cycle(1'b0, 1'b0, 32'h0);
        exp_fetch = FLUSH ? 32'd12 : 32'd16;
        chk("wrap_pc",    PC, 32'h0);
        chk("wrap_addr",  32'(imem_addr), 32'h0);
        chk("wrap_instr", IFID_instr, mem[31]);
        chk("wrap_pc4",   IFID_PC4, 32'h0);
        chk("wrap_fcnt",  32'(fetch_count), exp_fetch);

        // Mid-run asynchronous reset at PC=72
        cycle(1'b0, 1'b1, 32'd72);
        chk("pre_rst_pc", PC, 32'd72);
        chk("pre_rst_fcnt", 32'(fetch_count), FLUSH ? 32'd12 : 32'd17);
        branch_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pc",    PC, 32'h0);
        chk("arst_instr", IFID_instr, 32'h0);
        chk("arst_pc4",   IFID_PC4, 32'h0);
        chk("arst_valid", 32'(IFID_valid), 32'h0);
        chk("arst_fcnt",  32'(fetch_count), 32'h0);
        chk("arst_scnt",  32'(stall_count), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        chk("restart_pc",    PC, 32'd4);
        chk("restart_instr", IFID_instr, mem[0]);
        chk("restart_fcnt",  32'(fetch_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
